// File: rtl/pps_conditioner.sv
// pps_conditioner: synchronises and deglitches the raw GPS PPS pin, qualifies each
// pulse interval against the nominal second, and emits a clean single-cycle strobe,
// free-running from the last good period for a bounded time when the GPS drops out.
module pps_conditioner #(
  parameter int unsigned SYS_CLK_FREQ = 25_000_000,
  parameter int unsigned TOL_CYCLES   = 2500,
  parameter int unsigned MIN_WIDTH    = 4,
  parameter int unsigned LOCK_COUNT   = 3,
  parameter int unsigned HOLD_SECONDS = 60
) (
  input  logic        SYS_CLK,
  input  logic        RESET_N,
  input  logic        PPS_IN,
  output logic        PPS_OUT,
  output logic        LOCKED,
  output logic        HOLDOVER,
  output logic [31:0] PERIOD
);

  localparam int unsigned RUN_W  = $clog2(MIN_WIDTH + 2);
  localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam int unsigned HOLD_W = $clog2(HOLD_SECONDS + 1);

  localparam logic [31:0] WIN_MIN = 32'(SYS_CLK_FREQ - TOL_CYCLES);
  localparam logic [31:0] WIN_MAX = 32'(SYS_CLK_FREQ + TOL_CYCLES);
  localparam logic [31:0] TIMEOUT = 32'(SYS_CLK_FREQ + TOL_CYCLES + 1);
  // Holdover phase is TOL_CYCLES+1 in the timeout cycle; one more by the edge that
  // registers the timeout strobe, which keeps synthesised strobes on the nominal grid.
  localparam logic [31:0] H_START = 32'(TOL_CYCLES + 2);

  typedef enum logic [1:0] {
    ST_ACQUIRE  = 2'd0,
    ST_LOCKED   = 2'd1,
    ST_HOLDOVER = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                sync1_q, sync2_q;
  logic [RUN_W-1:0]    run_q, run_d;
  logic [31:0]         e_q, e_d;
  logic [31:0]         h_q, h_d;
  logic [31:0]         period_q, period_d;
  logic [GOOD_W-1:0]   good_q, good_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                strobe_q, strobe_d;
  logic                locked_q, locked_d;
  logic                holdover_q, holdover_d;

  logic                accept;
  logic                in_window;
  logic                good;

  // One accept per high period: the run length passes MIN_WIDTH exactly once.
  assign accept    = (run_q == RUN_W'(MIN_WIDTH));
  assign in_window = (e_q >= WIN_MIN) && (e_q <= WIN_MAX);
  assign good      = accept && in_window;

  // Two-flop synchroniser for the asynchronous PPS pin.
  always_ff @(posedge SYS_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= PPS_IN;
      sync2_q <= sync1_q;
    end
  end

  // Conditioner state and counters.
  always_ff @(posedge SYS_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= ST_ACQUIRE;
      run_q      <= '0;
      e_q        <= '1;
      h_q        <= '0;
      period_q   <= 32'(SYS_CLK_FREQ);
      good_q     <= '0;
      hold_q     <= '0;
      strobe_q   <= 1'b0;
      locked_q   <= 1'b0;
      holdover_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      e_q        <= e_d;
      h_q        <= h_d;
      period_q   <= period_d;
      good_q     <= good_d;
      hold_q     <= hold_d;
      strobe_q   <= strobe_d;
      locked_q   <= locked_d;
      holdover_q <= holdover_d;
    end
  end

  // Next-state, counter updates and strobe decision.
  always_comb begin
    state_d  = state_q;
    e_d      = (e_q == '1) ? e_q : e_q + 32'd1;
    h_d      = h_q;
    period_d = period_q;
    good_d   = good_q;
    hold_d   = hold_q;
    strobe_d = 1'b0;

    if (!sync2_q) begin
      run_d = '0;
    end else if (run_q == RUN_W'(MIN_WIDTH + 1)) begin
      run_d = run_q;
    end else begin
      run_d = run_q + RUN_W'(1);
    end

    if (good) begin
      period_d = e_q;
    end

    case (state_q)
      ST_ACQUIRE: begin
        if (accept) begin
          e_d = 32'd1;
          if (!in_window) begin
            good_d = '0;
          end else if (good_q == GOOD_W'(LOCK_COUNT - 1)) begin
            good_d   = GOOD_W'(LOCK_COUNT);
            state_d  = ST_LOCKED;
            strobe_d = 1'b1;
          end else begin
            good_d = good_q + GOOD_W'(1);
          end
        end
      end
      ST_LOCKED: begin
        // Early edges fall through untouched: no strobe, E keeps counting.
        if (e_q == TIMEOUT) begin
          state_d  = ST_HOLDOVER;
          strobe_d = 1'b1;
          h_d      = H_START;
          hold_d   = HOLD_W'(1);
        end else if (good) begin
          e_d      = 32'd1;
          strobe_d = 1'b1;
        end
      end
      ST_HOLDOVER: begin
        h_d = h_q + 32'd1;
        if (accept) begin
          state_d = ST_ACQUIRE;
          good_d  = '0;
          e_d     = 32'd1;
        end else if (h_q == period_q) begin
          if (hold_q == HOLD_W'(HOLD_SECONDS)) begin
            state_d = ST_ACQUIRE;
            good_d  = '0;
          end else begin
            strobe_d = 1'b1;
            h_d      = 32'd1;
            hold_d   = hold_q + HOLD_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_ACQUIRE;
        good_d  = '0;
      end
    endcase

    locked_d   = (state_d == ST_LOCKED);
    holdover_d = (state_d == ST_HOLDOVER);
  end

  assign PPS_OUT  = strobe_q;
  assign LOCKED   = locked_q;
  assign HOLDOVER = holdover_q;
  assign PERIOD   = period_q;

endmodule

// File: tb/tb_pps_conditioner.sv
// Directed bench for pps_conditioner with a 1000-cycle nominal second.
module tb_pps_conditioner;

  logic        SYS_CLK;
  logic        RESET_N;
  logic        PPS_IN;
  logic        PPS_OUT;
  logic        LOCKED;
  logic        HOLDOVER;
  logic [31:0] PERIOD;

  int checks = 0;
  int errors = 0;

  // Per-window capture of strobes and probed status.
  int          st_cnt;
  int          st_idx   [4];
  logic        st_lk    [4];
  logic        st_ho    [4];
  logic        st_prelk [4];
  logic [31:0] st_per   [4];
  logic        pr_lk;
  logic        pr_ho;

  pps_conditioner #(
    .SYS_CLK_FREQ(1000),
    .TOL_CYCLES  (10),
    .MIN_WIDTH   (4),
    .LOCK_COUNT  (3),
    .HOLD_SECONDS(2)
  ) dut (
    .SYS_CLK (SYS_CLK),
    .RESET_N (RESET_N),
    .PPS_IN  (PPS_IN),
    .PPS_OUT (PPS_OUT),
    .LOCKED  (LOCKED),
    .HOLDOVER(HOLDOVER),
    .PERIOD  (PERIOD)
  );

  initial SYS_CLK = 1'b0;
  always #5 SYS_CLK = ~SYS_CLK;

  // Drive one window of 'total' cycles starting at a negedge. Index k is the posedge
  // that samples the k-th PPS_IN value; outputs are read on the following negedge.
  task automatic drive_window(input int r0, input int l0, input int r1, input int l1,
                              input int total, input int probe);
    logic prev_lk;
    st_cnt  = 0;
    pr_lk   = 1'bx;
    pr_ho   = 1'bx;
    prev_lk = LOCKED;
    for (int i = 0; i < 4; i++) begin
      st_idx[i] = -1; st_lk[i] = 1'bx; st_ho[i] = 1'bx; st_prelk[i] = 1'bx; st_per[i] = 'x;
    end
    for (int k = 0; k < total; k++) begin
      PPS_IN = ((k >= r0) && (k < r0 + l0)) || ((k >= r1) && (k < r1 + l1));
      @(negedge SYS_CLK);
      if (k == probe) begin
        pr_lk = LOCKED;
        pr_ho = HOLDOVER;
      end
      if (PPS_OUT === 1'b1) begin
        if (st_cnt < 4) begin
          st_idx[st_cnt]   = k;
          st_lk[st_cnt]    = LOCKED;
          st_ho[st_cnt]    = HOLDOVER;
          st_prelk[st_cnt] = prev_lk;
          st_per[st_cnt]   = PERIOD;
        end
        st_cnt++;
      end
      prev_lk = LOCKED;
    end
    PPS_IN = 1'b0;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    for (int k = 0; k < 20; k++) begin
      PPS_IN = ((k % 3) != 0);
      @(negedge SYS_CLK);
      checks++; if ({PPS_OUT, LOCKED, HOLDOVER} !== 3'b000) begin errors++;
        $display("FAIL reset_outputs cycle %0d: got %b expected 000", k, {PPS_OUT, LOCKED, HOLDOVER}); end
      checks++; if (PERIOD !== 32'd1000) begin errors++;
        $display("FAIL reset_period cycle %0d: got %0d expected 1000", k, PERIOD); end
    end
    PPS_IN  = 1'b0;
    RESET_N = 1'b1;
    drive_window(0, 0, 0, 0, 10, -1);
    checks++; if (st_cnt !== 0) begin errors++;
      $display("FAIL reset_idle_strobes: got %0d expected 0", st_cnt); end
  endtask

  task automatic test_lock();
    for (int w = 1; w <= 3; w++) begin
      drive_window(0, 100, 0, 0, 1000, -1);
      checks++; if (st_cnt !== 0) begin errors++;
        $display("FAIL lock_edge%0d_strobes: got %0d expected 0", w, st_cnt); end
    end
    checks++; if (LOCKED !== 1'b0) begin errors++;
      $display("FAIL lock_pre_locked: got %b expected 0", LOCKED); end
    drive_window(0, 100, 0, 0, 1000, -1);
    checks++; if (st_cnt !== 1) begin errors++;
      $display("FAIL lock_edge4_strobes: got %0d expected 1", st_cnt); end
    checks++; if (st_idx[0] !== 6) begin errors++;
      $display("FAIL lock_edge4_latency: got %0d expected 6", st_idx[0]); end
    checks++; if ({st_prelk[0], st_lk[0], st_ho[0]} !== 3'b010) begin errors++;
      $display("FAIL lock_edge4_status: got %b expected 010", {st_prelk[0], st_lk[0], st_ho[0]}); end
    checks++; if (st_per[0] !== 32'd1000) begin errors++;
      $display("FAIL lock_edge4_period: got %0d expected 1000", st_per[0]); end
    drive_window(0, 100, 0, 0, 1000, -1);
    checks++; if (st_cnt !== 1 || st_idx[0] !== 6) begin errors++;
      $display("FAIL lock_edge5: got cnt %0d idx %0d expected cnt 1 idx 6", st_cnt, st_idx[0]); end
  endtask

  task automatic test_glitch_drift();
    drive_window(0, 100, 500, 3, 1005, -1);
    checks++; if (st_cnt !== 1 || st_idx[0] !== 6) begin errors++;
      $display("FAIL glitch_strobes: got cnt %0d idx %0d expected cnt 1 idx 6", st_cnt, st_idx[0]); end
    drive_window(0, 100, 0, 0, 1010, -1);
    checks++; if (st_cnt !== 1 || st_per[0] !== 32'd1005) begin errors++;
      $display("FAIL drift_1005: got cnt %0d period %0d expected cnt 1 period 1005", st_cnt, st_per[0]); end
    drive_window(0, 100, 0, 0, 990, -1);
    checks++; if (st_cnt !== 1 || st_per[0] !== 32'd1010) begin errors++;
      $display("FAIL window_max_1010: got cnt %0d period %0d expected cnt 1 period 1010", st_cnt, st_per[0]); end
    drive_window(0, 100, 0, 0, 1000, -1);
    checks++; if (st_cnt !== 1 || st_per[0] !== 32'd990) begin errors++;
      $display("FAIL window_min_990: got cnt %0d period %0d expected cnt 1 period 990", st_cnt, st_per[0]); end
  endtask

  task automatic test_early_edge();
    drive_window(0, 100, 500, 100, 1000, -1);
    checks++; if (st_cnt !== 1 || st_idx[0] !== 6) begin errors++;
      $display("FAIL early_500: got cnt %0d idx %0d expected cnt 1 idx 6", st_cnt, st_idx[0]); end
    drive_window(0, 100, 0, 0, 989, -1);
    checks++; if (st_cnt !== 1 || st_per[0] !== 32'd1000 || st_lk[0] !== 1'b1) begin errors++;
      $display("FAIL early_after_500: got cnt %0d period %0d locked %b expected 1 1000 1", st_cnt, st_per[0], st_lk[0]); end
    drive_window(0, 5, 0, 0, 11, -1);
    checks++; if (st_cnt !== 0) begin errors++;
      $display("FAIL early_989: got %0d strobes expected 0", st_cnt); end
    drive_window(0, 100, 0, 0, 1000, -1);
    checks++; if (st_cnt !== 1 || st_idx[0] !== 6 || st_per[0] !== 32'd1000) begin errors++;
      $display("FAIL early_after_989: got cnt %0d idx %0d period %0d expected 1 6 1000", st_cnt, st_idx[0], st_per[0]); end
    checks++; if (LOCKED !== 1'b1) begin errors++;
      $display("FAIL early_still_locked: got %b expected 1", LOCKED); end
  endtask

  task automatic test_holdover();
    drive_window(0, 100, 0, 0, 3100, 3005);
    checks++; if (st_cnt !== 3) begin errors++;
      $display("FAIL hold_strobe_count: got %0d expected 3", st_cnt); end
    checks++; if (st_idx[0] !== 6 || st_idx[1] !== 1017 || st_idx[2] !== 2006) begin errors++;
      $display("FAIL hold_strobe_times: got %0d %0d %0d expected 6 1017 2006", st_idx[0], st_idx[1], st_idx[2]); end
    checks++; if ({st_lk[1], st_ho[1], st_lk[2], st_ho[2]} !== 4'b0101) begin errors++;
      $display("FAIL hold_status: got %b expected 0101", {st_lk[1], st_ho[1], st_lk[2], st_ho[2]}); end
    checks++; if (pr_ho !== 1'b1) begin errors++;
      $display("FAIL hold_before_expiry: got %b expected 1", pr_ho); end
    checks++; if ({LOCKED, HOLDOVER} !== 2'b00) begin errors++;
      $display("FAIL hold_expired_state: got %b expected 00", {LOCKED, HOLDOVER}); end
  endtask

  task automatic test_holdover_restore();
    for (int w = 1; w <= 3; w++) begin
      drive_window(0, 100, 0, 0, 1000, -1);
      checks++; if (st_cnt !== 0) begin errors++;
        $display("FAIL relock_edge%0d_strobes: got %0d expected 0", w, st_cnt); end
    end
    drive_window(0, 100, 0, 0, 1000, -1);
    checks++; if (st_cnt !== 1 || st_idx[0] !== 6) begin errors++;
      $display("FAIL relock_edge4: got cnt %0d idx %0d expected 1 6", st_cnt, st_idx[0]); end
    drive_window(0, 100, 0, 0, 1500, -1);
    checks++; if (st_cnt !== 2 || st_idx[1] !== 1017 || HOLDOVER !== 1'b1) begin errors++;
      $display("FAIL restore_enter_hold: got cnt %0d idx %0d ho %b expected 2 1017 1", st_cnt, st_idx[1], HOLDOVER); end
    drive_window(0, 100, 0, 0, 1003, 6);
    checks++; if (st_cnt !== 0 || {pr_lk, pr_ho} !== 2'b00) begin errors++;
      $display("FAIL restore_edge: got cnt %0d status %b expected 0 00", st_cnt, {pr_lk, pr_ho}); end
    for (int w = 1; w <= 2; w++) begin
      drive_window(0, 100, 0, 0, 1003, -1);
      checks++; if (st_cnt !== 0) begin errors++;
        $display("FAIL restore_good%0d_strobes: got %0d expected 0", w, st_cnt); end
    end
    drive_window(0, 100, 0, 0, 1003, -1);
    checks++; if (st_cnt !== 1 || st_idx[0] !== 6 || st_lk[0] !== 1'b1 || st_per[0] !== 32'd1003) begin errors++;
      $display("FAIL restore_relock: got cnt %0d idx %0d lk %b period %0d expected 1 6 1 1003", st_cnt, st_idx[0], st_lk[0], st_per[0]); end
  endtask

  task automatic test_reset_mid_holdover();
    drive_window(0, 100, 0, 0, 1500, -1);
    checks++; if (st_cnt !== 2 || st_per[0] !== 32'd1003 || HOLDOVER !== 1'b1) begin errors++;
      $display("FAIL midrst_enter_hold: got cnt %0d period %0d ho %b expected 2 1003 1", st_cnt, st_per[0], HOLDOVER); end
    RESET_N = 1'b0;
    #1;
    checks++; if ({PPS_OUT, LOCKED, HOLDOVER} !== 3'b000 || PERIOD !== 32'd1000) begin errors++;
      $display("FAIL midrst_async: got %b period %0d expected 000 period 1000", {PPS_OUT, LOCKED, HOLDOVER}, PERIOD); end
    @(negedge SYS_CLK);
    RESET_N = 1'b1;
    for (int w = 1; w <= 3; w++) begin
      drive_window(0, 4, 0, 0, 1000, -1);
      checks++; if (st_cnt !== 0) begin errors++;
        $display("FAIL midrst_reacq%0d_strobes: got %0d expected 0", w, st_cnt); end
    end
    drive_window(0, 4, 0, 0, 1000, -1);
    checks++; if (st_cnt !== 1 || st_idx[0] !== 6 || st_lk[0] !== 1'b1 || st_per[0] !== 32'd1000) begin errors++;
      $display("FAIL midrst_relock: got cnt %0d idx %0d lk %b period %0d expected 1 6 1 1000", st_cnt, st_idx[0], st_lk[0], st_per[0]); end
  endtask

  initial begin
    RESET_N = 1'b0;
    PPS_IN  = 1'b0;
    test_reset();
    test_lock();
    test_glitch_drift();
    test_early_edge();
    test_holdover();
    test_holdover_restore();
    test_reset_mid_holdover();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
